// File: rtl/pet_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pet_pkg : action codes, life states and need limits shared by the pet blocks
// rev 1.0
// ---------------------------------------------------------------------------
package pet_pkg;

  localparam logic [2:0] ACT_FEED     = 3'd0;
  localparam logic [2:0] ACT_PLAY     = 3'd1;
  localparam logic [2:0] ACT_CLEAN    = 3'd2;
  localparam logic [2:0] ACT_MEDICINE = 3'd3;
  localparam logic [2:0] ACT_SLEEP    = 3'd4;
  localparam logic [2:0] ACT_WAKE     = 3'd5;
  localparam logic [2:0] ACT_PET      = 3'd6;

  typedef enum logic [1:0] {
    ST_AWAKE    = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_DEAD     = 2'd2
  } life_state_e;

  localparam logic [3:0] NEED_MAX4  = 4'd15;
  localparam logic [4:0] NEED_MAX5  = 5'd31;
  localparam logic [3:0] NEED_ALERT = 4'd12;

  typedef logic signed [5:0] need_delta_t;

endpackage
`default_nettype wire

// File: rtl/pet_needs_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pet_needs_if : valid/ready action channel into the need tracker
// rev 1.0
// ---------------------------------------------------------------------------
interface pet_needs_if;
  logic       action_valid;
  logic [2:0] action_code;
  logic       action_ready;

  modport master (output action_valid, output action_code, input action_ready);
  modport slave  (input action_valid, input action_code, output action_ready);
endinterface
`default_nettype wire

// File: rtl/need_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// need_counter : saturating need register with its own tick period divider
// rev 1.0
// ---------------------------------------------------------------------------
module need_counter
  import pet_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PERIOD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             grow_en_i,
  input  logic             clear_i,
  input  logic             freeze_i,
  input  need_delta_t      delta_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] value_next_o
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = WIDTH + 3;
  localparam logic signed [SW-1:0] MAX_S = SW'((1 << WIDTH) - 1);

  logic [CW-1:0]        per_q, per_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic [WIDTH-1:0]     base_w;
  logic signed [SW-1:0] sum_w;
  logic                 inc_w;

  assign inc_w = tick_i && (per_q == CW'(PERIOD - 1));

  // Growth and action delta are folded into one signed sum, then clamped once.
  always_comb begin
    per_d   = per_q;
    value_d = value_q;
    base_w  = clear_i ? '0 : value_q;
    sum_w   = $signed({3'b000, base_w})
            + $signed({{(SW-1){1'b0}}, inc_w & grow_en_i})
            + $signed({{(SW-6){delta_i[5]}}, delta_i});
    if (!freeze_i) begin
      if (tick_i) per_d = inc_w ? '0 : per_q + CW'(1);
      if (sum_w[SW-1])        value_d = '0;
      else if (sum_w > MAX_S) value_d = MAX_S[WIDTH-1:0];
      else                    value_d = sum_w[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_q   <= '0;
      value_q <= '0;
    end else begin
      per_q   <= per_d;
      value_q <= value_d;
    end
  end

  assign value_o      = value_q;
  assign value_next_o = value_d;

endmodule
`default_nettype wire

// File: rtl/pet_needs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pet_needs : six pet need counters driven by a game tick and user actions
// rev 1.0
// ---------------------------------------------------------------------------
module pet_needs
  import pet_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int HUNGER_PER  = 2,
  parameter int HAPPY_PER   = 3,
  parameter int HYGIENE_PER = 4,
  parameter int ENERGY_PER  = 3,
  parameter int SOCIAL_PER  = 5
) (
  input  logic        clk,
  input  logic        reset,
  pet_needs_if.slave  act,
  output logic [3:0]  hunger,
  output logic [4:0]  happiness,
  output logic [3:0]  health,
  output logic [3:0]  hygiene,
  output logic [3:0]  energy,
  output logic [3:0]  social,
  output logic        tick,
  output logic        sleeping,
  output logic        dead
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, sleeping_q, dead_q;
  logic          tick_w, acc_w, awake_w, asleep_w, clean_w, sick_w;
  life_state_e   state_q, state_d;
  need_delta_t   d_hunger, d_happy, d_health, d_energy, d_social;
  logic [3:0]    hunger_d, health_d, energy_d, hygiene_d, social_d;
  logic [4:0]    happy_d;

  assign awake_w  = (state_q == ST_AWAKE);
  assign asleep_w = (state_q == ST_SLEEPING);
  assign acc_w    = act.action_valid & ~dead_q;
  assign tick_w   = (presc_q == PW'(TICK_DIV - 1)) & ~dead_q;
  assign presc_d  = dead_q ? presc_q : (tick_w ? '0 : presc_q + PW'(1));
  assign sick_w   = (hunger >= NEED_ALERT) || (hygiene >= NEED_ALERT);

  always_comb begin
    d_hunger = '0;
    d_happy  = '0;
    d_health = '0;
    d_energy = '0;
    d_social = '0;
    clean_w  = 1'b0;
    if (acc_w && awake_w) begin
      case (act.action_code)
        ACT_FEED:     d_hunger = -6'sd4;
        ACT_PLAY:     begin d_happy = -6'sd4; d_social = -6'sd2; d_energy = 6'sd2; end
        ACT_CLEAN:    clean_w  = 1'b1;
        ACT_MEDICINE: begin d_health = -6'sd4; d_happy = 6'sd1; end
        ACT_PET:      begin d_social = -6'sd4; d_happy = -6'sd1; end
        default:      ;
      endcase
    end
    if (tick_w && asleep_w) d_energy = -6'sd1;
  end

  // Death is judged on post-update values so a same-edge action can avert it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_AWAKE:    if (acc_w && act.action_code == ACT_SLEEP) state_d = ST_SLEEPING;
      ST_SLEEPING: if ((acc_w && act.action_code == ACT_WAKE) || energy_d == 4'd0)
                     state_d = ST_AWAKE;
      default:     state_d = state_q;
    endcase
    if (!dead_q && (hunger_d == NEED_MAX4 || health_d == NEED_MAX4)) state_d = ST_DEAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      state_q    <= ST_AWAKE;
      sleeping_q <= 1'b0;
      dead_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_w;
      state_q    <= state_d;
      sleeping_q <= (state_d == ST_SLEEPING);
      dead_q     <= (state_d == ST_DEAD);
    end
  end

  need_counter #(.WIDTH(4), .PERIOD(HUNGER_PER)) u_hunger (
    .clk(clk), .reset(reset), .tick_i(tick_w), .grow_en_i(1'b1), .clear_i(1'b0),
    .freeze_i(dead_q), .delta_i(d_hunger), .value_o(hunger), .value_next_o(hunger_d));

  need_counter #(.WIDTH(5), .PERIOD(HAPPY_PER)) u_happy (
    .clk(clk), .reset(reset), .tick_i(tick_w), .grow_en_i(1'b1), .clear_i(1'b0),
    .freeze_i(dead_q), .delta_i(d_happy), .value_o(happiness), .value_next_o(happy_d));

  need_counter #(.WIDTH(4), .PERIOD(1)) u_health (
    .clk(clk), .reset(reset), .tick_i(tick_w), .grow_en_i(sick_w), .clear_i(1'b0),
    .freeze_i(dead_q), .delta_i(d_health), .value_o(health), .value_next_o(health_d));

  need_counter #(.WIDTH(4), .PERIOD(HYGIENE_PER)) u_hygiene (
    .clk(clk), .reset(reset), .tick_i(tick_w), .grow_en_i(1'b1), .clear_i(clean_w),
    .freeze_i(dead_q), .delta_i('0), .value_o(hygiene), .value_next_o(hygiene_d));

  need_counter #(.WIDTH(4), .PERIOD(ENERGY_PER)) u_energy (
    .clk(clk), .reset(reset), .tick_i(tick_w & awake_w), .grow_en_i(1'b1), .clear_i(1'b0),
    .freeze_i(dead_q), .delta_i(d_energy), .value_o(energy), .value_next_o(energy_d));

  need_counter #(.WIDTH(4), .PERIOD(SOCIAL_PER)) u_social (
    .clk(clk), .reset(reset), .tick_i(tick_w), .grow_en_i(1'b1), .clear_i(1'b0),
    .freeze_i(dead_q), .delta_i(d_social), .value_o(social), .value_next_o(social_d));

  assign act.action_ready = ~dead_q;
  assign tick             = tick_q;
  assign sleeping         = sleeping_q;
  assign dead             = dead_q;

endmodule
`default_nettype wire

// File: tb/tb_pet_needs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pet_needs : directed checks of pet_needs with a 4-cycle game tick
// rev 1.0
// ---------------------------------------------------------------------------
module tb_pet_needs;
  import pet_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hunger, health, hygiene, energy, social;
  logic [4:0] happiness;
  logic       tick, sleeping, dead;
  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  int         ticks_seen;

  pet_needs_if act();

  pet_needs #(
    .TICK_DIV(4), .HUNGER_PER(2), .HAPPY_PER(3),
    .HYGIENE_PER(4), .ENERGY_PER(3), .SOCIAL_PER(5)
  ) dut (
    .clk(clk), .reset(reset), .act(act),
    .hunger(hunger), .happiness(happiness), .health(health), .hygiene(hygiene),
    .energy(energy), .social(social), .tick(tick), .sleeping(sleeping), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_act(input logic [2:0] code);
    act.action_valid = 1'b1;
    act.action_code  = code;
    step();
    act.action_valid = 1'b0;
  endtask

  // Idle up to a target cycle; optionally feed every 32 cycles to keep hunger low.
  task automatic run_to(input int target, input bit feed);
    while (cyc < target) begin
      if (feed && (cyc % 32 == 0)) do_act(ACT_FEED);
      else step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    act.action_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    act.action_valid = 1'b0;
    act.action_code  = 3'd0;
    step();
    step();
    chk("rst_hunger", hunger, 0);
    chk("rst_happy", happiness, 0);
    chk("rst_energy", energy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_sleep", sleeping, 0);
    chk("rst_dead", dead, 0);
    chk("rst_ready", act.action_ready, 1);
    reset = 1'b0;
    cyc = 0;

    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("tick_c%0d", k), tick, (k % 4 == 0) ? 1 : 0);
    end
    chk("c16_hunger", hunger, 2);
    chk("c16_energy", energy, 1);
    chk("c16_happy", happiness, 1);
    chk("c16_hygiene", hygiene, 1);
    chk("c16_social", social, 0);
    chk("c16_health", health, 0);

    do_act(ACT_FEED);
    chk("feed_sat0", hunger, 0);

    run_to(96, 0);
    chk("c96_hunger", hunger, 10);
    run_to(103, 0);
    do_act(ACT_FEED);
    chk("feed_tick_hunger", hunger, 7);
    chk("feed_tick_tick", tick, 1);

    run_to(167, 0);
    chk("c167_hunger", hunger, 14);
    chk("c167_dead", dead, 0);
    step();
    chk("death_dead", dead, 1);
    chk("death_hunger", hunger, 15);
    chk("death_ready", act.action_ready, 0);
    chk("death_health", health, 6);

    ticks_seen = 0;
    act.action_valid = 1'b1;
    act.action_code  = ACT_PLAY;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tick) ticks_seen++;
    end
    act.action_valid = 1'b0;
    chk("frz_ticks", ticks_seen, 0);
    chk("frz_hunger", hunger, 15);
    chk("frz_happy", happiness, 14);
    chk("frz_hygiene", hygiene, 10);
    chk("frz_energy", energy, 14);
    chk("frz_social", social, 8);
    chk("frz_health", health, 6);
    chk("frz_dead", dead, 1);

    do_reset();
    chk("rr_dead", dead, 0);
    chk("rr_hunger", hunger, 0);
    chk("rr_health", health, 0);
    chk("rr_ready", act.action_ready, 1);

    run_to(36, 0);
    chk("c36_energy", energy, 3);
    do_act(ACT_SLEEP);
    chk("sleep_on", sleeping, 1);
    do_act(ACT_PLAY);
    chk("slp_play_happy", happiness, 3);
    chk("slp_play_social", social, 1);
    chk("slp_play_energy", energy, 3);
    chk("slp_ready", act.action_ready, 1);
    run_to(44, 0);
    chk("c44_energy", energy, 1);
    chk("c44_sleep", sleeping, 1);
    step();
    step();
    step();
    step();
    chk("c48_energy", energy, 0);
    chk("c48_awake", sleeping, 0);
    chk("c48_hunger", hunger, 6);

    do_reset();
    run_to(212, 1);
    chk("c212_hygiene", hygiene, 13);
    chk("c212_health", health, 5);
    do_act(ACT_CLEAN);
    chk("clean_hygiene", hygiene, 0);
    chk("clean_health", health, 5);
    run_to(240, 1);
    chk("c240_health", health, 5);

    run_to(360, 1);
    chk("c360_happy", happiness, 30);
    chk("c360_social", social, 15);
    do_act(ACT_MEDICINE);
    chk("med1_happy", happiness, 31);
    do_act(ACT_MEDICINE);
    do_act(ACT_MEDICINE);
    chk("med3_happy", happiness, 31);
    chk("med3_health", health, 0);
    do_act(ACT_PET);
    do_act(ACT_PET);
    do_act(ACT_PET);
    chk("pet3_social", social, 3);
    chk("pet3_happy", happiness, 28);
    do_act(ACT_PLAY);
    chk("play_social", social, 1);
    chk("play_happy", happiness, 24);
    chk("play_energy", energy, 15);
    do_act(ACT_PET);
    chk("pet_social0", social, 0);
    chk("pet_happy", happiness, 23);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pet_needs.md
Name: pet_needs

Overview:
- Upstream stage of the status block: owns the six need counters (hunger, happiness, health, hygiene, energy, social) and drives them directly into it.
- Needs grow (worse = higher) on a prescaled game tick and are relieved by user actions arriving over a valid/ready handshake.
- Tracks an AWAKE/SLEEPING/DEAD life state; death freezes all counters until reset.

Parameters:
- TICK_DIV, 1000, clk cycles per game tick (>=2)
- HUNGER_PER, 2, ticks per hunger +1
- HAPPY_PER, 3, ticks per happiness +1
- HYGIENE_PER, 4, ticks per hygiene +1
- ENERGY_PER, 3, ticks per energy +1 (AWAKE only)
- SOCIAL_PER, 5, ticks per social +1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- action_valid  in  1  action request present
- action_code  in  3  0 FEED, 1 PLAY, 2 CLEAN, 3 MEDICINE, 4 SLEEP, 5 WAKE, 6 PET, 7 reserved
- action_ready  out  1  block accepts action this cycle
- hunger  out  4  0 = sated, 15 = starved
- happiness  out  5  0 = happy, 31 = miserable
- health  out  4  0 = healthy, 15 = critical
- hygiene  out  4  0 = clean, 15 = filthy
- energy  out  4  0 = rested, 15 = exhausted
- social  out  4  0 = content, 15 = lonely
- tick  out  1  one-cycle pulse per game tick
- sleeping  out  1  state == SLEEPING
- dead  out  1  state == DEAD

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset: all need outputs 0; tick 0; state AWAKE; sleeping 0; dead 0; prescaler and per-need counters 0. Reset mid-operation discards any in-flight action.
- Prescaler: counts 0..TICK_DIV-1; tick pulses for exactly one cycle on wrap. First tick is TICK_DIV cycles after reset deasserts.
- Per-need counter: advances on tick. On reaching its PER, it clears and raises that need's increment (+1) in the same cycle.
- Health: on each tick, +1 if hunger>=12 or hygiene>=12, else unchanged.
- All arithmetic saturates: 4-bit needs clamp to 0..15, happiness to 0..31. There is no wrap-around.
- Handshake: an action is accepted when action_valid & action_ready, and takes effect on that same clock edge. No queuing is needed, since ready is combinational from state only.
- action_ready: 1 in AWAKE and SLEEPING, 0 in DEAD.
- AWAKE actions:
  - FEED: hunger-4
  - PLAY: happiness-4, social-2, energy+2
  - CLEAN: hygiene:=0
  - MEDICINE: health-4, happiness+1
  - SLEEP: go to SLEEPING
  - WAKE: no-op
  - PET: social-4, happiness-1
  - reserved: no-op
- SLEEPING:
  - energy does not grow; energy-1 per tick instead.
  - Other needs keep growing.
  - Only WAKE has an effect (go to AWAKE). All other codes are accepted and dropped.
  - Automatic transition to AWAKE on the edge where energy becomes 0.
- DEAD:
  - Entered on the edge where hunger or health becomes 15.
  - All counters and the prescaler freeze. tick stays 0 and ready stays 0.
  - Only reset leaves DEAD.
- Simultaneous tick and action on the same need: result = clamp(old + tick_inc - action_dec), computed in a single update. For CLEAN, hygiene = 0 + tick_inc.
- Death check uses the post-update values, so an action that lowers hunger from 15-bound in the same cycle prevents death.
- Outputs are registered; latency from action acceptance to visible need change is 1 cycle.

Decomposition:
- Shared package pet_pkg holds:
  - action_code localparams (ACT_FEED..ACT_PET)
  - life-state encoding (ST_AWAKE, ST_SLEEPING, ST_DEAD)
  - NEED_MAX4 = 15, NEED_MAX5 = 31
  - threshold constant NEED_ALERT = 12, shared with the status block
- One sub-module, need_counter: parameterized width and period, with a tick input, signed delta input, saturating register and a freeze input. It is instantiated six times. Health uses period 1 with a gated increment.

Test Plan:
- Reset, then TICK_DIV=4, HUNGER_PER=2, idle 16 cycles -> tick pulses at cycles 4, 8, 12, 16; hunger=2; energy=1 (ENERGY_PER=3); all other needs as per their periods.
- hunger=10, FEED accepted on the same cycle as a hunger increment -> next cycle hunger=7 (10+1-4); a FEED at hunger=2 saturates to 0.
- Drive hunger to 15 -> dead=1, action_ready=0, counters frozen for 100 cycles; reset -> all zero, AWAKE.
- energy=3, SLEEP -> sleeping=1; after 3 ticks energy=0 and auto-wake; PLAY while sleeping -> accepted, no need changes.
- hygiene held >=12 for 5 ticks starting from health=0 -> health=5; CLEAN -> hygiene=0 and health growth stops.
- happiness=30, MEDICINE ×3 -> happiness saturates at 31; PET at social=1 -> social=0.
